// File: rtl/serial_word_assembler_pkg.sv
// Shared types and width helpers for the serial word assembler slice.
package serial_pkg;

    localparam int N_DEFAULT = 3;

    typedef enum logic {IDLE, COLLECT} asm_state_t;

    // Word width is always 2**N so the bit counter wraps naturally at W.
    function automatic int word_width(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/serial_word_assembler_if.sv
// Bit-serial input stream plus assembled-word output stream.
interface serial_word_assembler_if
    import serial_pkg::*;
#(
    parameter int N = N_DEFAULT
);

    logic                      in_valid;
    logic                      in_data;
    logic                      in_ready;
    logic                      msb_first;
    logic                      flush;
    logic                      out_valid;
    logic [word_width(N)-1:0]  out_data;
    logic                      out_ready;
    logic                      busy;

    modport master (
        output in_valid, in_data, msb_first, flush, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, msb_first, flush, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/serial_word_assembler_mirror.sv
// Combinational bit reversal of a 2**N-bit word.
module bit_mirror
    import serial_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [word_width(N)-1:0] in_i,
    output logic [word_width(N)-1:0] out_o
);

    localparam int W = word_width(N);

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign out_o[i] = in_i[W-1-i];
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel receiver: collects W bits, emits them as one word in
// the bit order chosen when the word's first bit arrived.
module serial_word_assembler
    import serial_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    serial_word_assembler_if.slave  bus
);

    localparam int           W          = word_width(N);
    localparam logic [N-1:0] LAST_COUNT = N'(W - 1);

    asm_state_t     state_q;
    logic [N-1:0]   count_q;
    logic [W-1:0]   sr_q;
    logic [W-1:0]   sr_d;
    logic [W-1:0]   sr_mirror;
    logic           order_q;
    logic           busy_q;
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    logic [W-1:0]   out_data_d;
    logic           in_ready;
    logic           accept;
    logic           last_bit;

    assign last_bit = (count_q == LAST_COUNT);
    assign in_ready = ~(last_bit && out_valid_q && !bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign sr_d       = (sr_q << 1) | W'(bus.in_data);
    assign out_data_d = order_q ? sr_d : sr_mirror;

    bit_mirror #(.N(N)) u_mirror (
        .in_i  (sr_d),
        .out_o (sr_mirror)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

    // Collection FSM, bit counter, shift register and output word register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            sr_q        <= '0;
            order_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (bus.flush) begin
                state_q <= IDLE;
                count_q <= '0;
                sr_q    <= '0;
                busy_q  <= 1'b0;
            end else if (accept) begin
                sr_q    <= sr_d;
                count_q <= count_q + 1'b1;
                if (state_q == IDLE) begin
                    order_q <= bus.msb_first;
                end
                if (last_bit) begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                    out_data_q  <= out_data_d;
                end else begin
                    state_q <= COLLECT;
                    busy_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed self-checking bench for serial_word_assembler with N = 3.
module tb_serial_word_assembler;

    logic clk;
    logic reset_n;
    int   testsRun;
    int   failCount;

    serial_word_assembler_if #(.N(3)) bus ();

    serial_word_assembler #(.N(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic data, input logic ms,
                                 input logic fl, input logic ordy);
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.msb_first = ms;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBits(input logic [7:0] bits, input int n, input logic ms,
                            input logic ordy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, bits[7-i], ms, 1'b0, ordy);
            tick();
        end
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        testsRun  = 0;
        failCount = 0;
        reset_n   = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("reset_out_data", 32'(bus.out_data), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h1);
        reset_n = 1'b1;

        sendBits(8'b1011_0010, 1, 1'b1, 1'b1);
        checkOutput("msb_busy_first", 32'(bus.busy), 32'h1);
        sendBits(8'b0110_0100, 6, 1'b1, 1'b1);
        checkOutput("msb_valid_early", 32'(bus.out_valid), 32'h0);
        sendBits(8'b0000_0000, 1, 1'b1, 1'b1);
        checkOutput("msb_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("msb_data", 32'(bus.out_data), 32'hB2);
        checkOutput("msb_busy_done", 32'(bus.busy), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("msb_valid_one_cycle", 32'(bus.out_valid), 32'h0);

        sendBits(8'b1011_0010, 8, 1'b0, 1'b1);
        checkOutput("lsb_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("lsb_data", 32'(bus.out_data), 32'h4D);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        sendBits(8'hA5, 8, 1'b1, 1'b0);
        checkOutput("bp_first_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("bp_first_data", 32'(bus.out_data), 32'hA5);
        sendBits(8'h3C, 7, 1'b1, 1'b0);
        checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("bp_hold_data", 32'(bus.out_data), 32'hA5);
        checkOutput("bp_busy", 32'(bus.busy), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
        tick();
        checkOutput("bp_stall_data", 32'(bus.out_data), 32'hA5);
        checkOutput("bp_stall_busy", 32'(bus.busy), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_in_ready_comb", 32'(bus.in_ready), 32'h1);
        tick();
        checkOutput("bp_taken", 32'(bus.out_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_in_ready_back", 32'(bus.in_ready), 32'h1);
        tick();
        checkOutput("bp_second_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("bp_second_data", 32'(bus.out_data), 32'h3C);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        sendBits(8'hE0, 3, 1'b1, 1'b1);
        checkOutput("flush_busy_before", 32'(bus.busy), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        checkOutput("flush_busy_after", 32'(bus.busy), 32'h0);
        sendBits(8'h00, 8, 1'b1, 1'b1);
        checkOutput("flush_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("flush_data", 32'(bus.out_data), 32'h00);

        sendBits(8'b1000_0000, 2, 1'b1, 1'b1);
        sendBits(8'b0000_0100, 6, 1'b0, 1'b1);
        checkOutput("order_lock_msb", 32'(bus.out_data), 32'h81);
        sendBits(8'b1000_0000, 2, 1'b0, 1'b1);
        sendBits(8'b0000_0000, 6, 1'b1, 1'b1);
        checkOutput("order_lock_lsb", 32'(bus.out_data), 32'h01);
        sendBits(8'b1100_0000, 8, 1'b0, 1'b1);
        checkOutput("order_next_lsb", 32'(bus.out_data), 32'h03);

        sendBits(8'h5A, 8, 1'b1, 1'b0);
        checkOutput("rst_pending", 32'(bus.out_valid), 32'h1);
        sendBits(8'hFF, 5, 1'b1, 1'b0);
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        checkOutput("rst_mid_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("rst_mid_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_mid_data", 32'(bus.out_data), 32'h0);
        checkOutput("rst_mid_in_ready", 32'(bus.in_ready), 32'h1);
        sendBits(8'hF0, 8, 1'b1, 1'b1);
        checkOutput("rst_after_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("rst_after_data", 32'(bus.out_data), 32'hF0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/serial_word_assembler.md
# serial_word_assembler

Receive-side serial-to-parallel converter. Accepts one bit per cycle over a valid/ready stream, assembles 2**N-bit words, and presents each completed word on a valid/ready output. A per-word order select fixes the bit order: MSB-first, with the first bit landing in bit W-1, or LSB-first, with the first bit landing in bit 0. It is the receiving end of the bit-serial links that feed the datapath's bit-order logic.

## Interface
- N, default 3: word width W = 2**N bits; counter width N.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  serial bit present.
- in_data  in  1  serial bit value.
- in_ready  out  1  bit accepted this cycle when in_valid & in_ready.
- msb_first  in  1  order select. 1: first bit goes to out_data[W-1]. 0: first bit goes to out_data[0]. Sampled only on the first bit of a word.
- flush  in  1  discards the partial word. Does not affect the output register.
- out_valid  out  1  completed word held in out_data.
- out_data  out  W  assembled word.
- out_ready  in  1  consumer takes the word when out_valid & out_ready.
- busy  out  1  partial word in progress (bit count ≠ 0).

## Operation
- Input FSM states:
  - IDLE: count = 0. IDLE -> COLLECT on an accepted bit when W > 1.
  - COLLECT: 1 ≤ count ≤ W-1. COLLECT -> IDLE on an accepted bit when count = W-1, or on flush.
- Accepting the first bit latches msb_first into order_q. msb_first changes during COLLECT are ignored.
- Shift register sr_q (W bits) shifts left, with the new bit entering at sr_q[0]. After W bits, the first bit received sits in sr_q[W-1].
- On completion, output word = sr_next when order_q = 1, or bit-mirror(sr_next) when order_q = 0. sr_next is the register value including the final bit.
- Output register: completion loads out_data and sets out_valid. The handshake clears out_valid unless a new completion occurs in the same cycle; then it reloads and out_valid stays 1.
- in_ready = 0 only when the pending bit would complete a word (count = W-1) and out_valid = 1 and out_ready = 0. Otherwise in_ready = 1. A new word can be collected while the previous word waits.
- flush takes priority over a same-cycle input bit: the bit is discarded, count -> 0, state -> IDLE. in_ready is unaffected by flush.
- Wrap-around: the counter is N bits wide and returns to 0 after W-1. It never saturates.

## Timing
- Reset (reset_n = 0 at a clk edge) forces: state IDLE, count 0, sr_q 0, order_q 0, out_valid 0, out_data 0, busy 0. in_ready is 1 after reset.
- Reset mid-word or with a word pending discards both. There is no partial output.
- Latency: out_valid rises on the clk edge that accepts the W-th bit. The word is visible in the cycle after that bit is presented.
- Throughput: one bit per cycle, one word per W cycles, with no bubbles while out_ready = 1.
- in_ready depends combinationally on out_ready. This is the only combinational input-to-output path.
- busy and all handshake outputs other than in_ready are registered.

## Structure
- Shared package serial_pkg:
  - localparam W = 2**N convention.
  - typedef enum logic {IDLE, COLLECT} asm_state_t.
- Sub-module bit_mirror (parameter N): purely combinational W-bit reversal. It is instantiated once on the completion path.
- The top module holds the FSM, counter, shift register and output register.

## Test plan
- N = 3, msb_first = 1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready = 1 -> out_data = 8'hB2, with out_valid high for exactly one cycle, the cycle after the 8th bit.
- Same bits with msb_first = 0 -> out_data = 8'h4D.
- out_ready = 0. Send 0xA5 MSB-first, then 7 bits of a second word (0x3C) -> out_valid held with 8'hA5. in_ready drops with the 8th bit of the second word pending. After one out_ready pulse, 8'hA5 is taken, the 8th bit is accepted next cycle, and out_data = 8'h3C.
- Three bits 1,1,1, then flush for one cycle with in_valid = 1, then 8 zeros -> busy falls after flush, and out_data = 8'h00, not contaminated.
- Start a word with msb_first = 1 and toggle it to 0 after 2 bits, bits 0x81 -> out_data = 8'h81, order unchanged. The next word uses msb_first = 0.
- reset_n low for one cycle after 5 bits, with a word pending -> out_valid = 0, busy = 0, out_data = 0. The next 8 bits of 0xF0 MSB-first produce 8'hF0.
